// File: rtl/aes128_key_schedule.sv
// aes128_key_schedule
//   Iterative AES-128 key expansion. A 128-bit master key is accepted while
//   idle. Round keys 0..10 are then presented one per accepted beat. Each
//   round key is derived from the previous one held in a register, so no
//   table of expanded keys is stored. A stalled consumer freezes the output.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-high
//   key_valid_i  master key present on key_i
//   key_i        master key, word w0 = key_i[127:96], byte 0 = key_i[127:120]
//   key_ready_o  idle, a key can be accepted
//   rk_valid_o   rk_o / rk_round_o hold a valid round key
//   rk_ready_i   consumer accepts the current round key
//   rk_o         round key, same ordering as key_i
//   rk_round_o   index of the round key on rk_o (0..10)
//   rk_last_o    high with rk_valid_o while round 10 is presented
module aes128_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         key_valid_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_round_o,
    output logic         rk_last_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // AES S-box, byte 0 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Byte b sits at bit offset (255-b)*8, which is {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One step of the key expansion: round key i from round key i-1.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(i), 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     round_q, round_d;
    logic           ready_q, ready_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [3:0]     round_inc_s;
    logic [127:0]   rk_next_s;

    assign round_inc_s = round_q + 4'd1;
    assign rk_next_s   = next_key(rk_q, round_inc_s);

    // Next-state logic: key acceptance, round advance and stall hold.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid_i) begin
                    rk_d    = key_i;
                    round_d = 4'd0;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (rk_ready_i) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                    end else begin
                        rk_d    = rk_next_s;
                        round_d = round_inc_s;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags are registered from the next state so outputs come straight off flops.
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_EMIT);
        last_d  = (state_d == ST_EMIT) && (round_d == LAST_ROUND);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rk_q    <= 128'h0;
            round_q <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign key_ready_o = ready_q;
    assign rk_valid_o  = valid_q;
    assign rk_o        = rk_q;
    assign rk_round_o  = round_q;
    assign rk_last_o   = last_q;

endmodule

// File: tb/tb_aes128_key_schedule.sv
module tb_aes128_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    aes128_key_schedule dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_valid_i (key_valid),
        .key_i       (key_in),
        .key_ready_o (key_ready),
        .rk_valid_o  (rk_valid),
        .rk_ready_i  (rk_ready),
        .rk_o        (rk),
        .rk_round_o  (rk_round),
        .rk_last_o   (rk_last)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [127:0] beats [$];
    int           acc_cyc [$];
    int           last_cyc [$];

    // ---------------- reference model (FIPS-197 from GF(2^8) arithmetic) ----
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ks[1407 - 128 * r -: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return ks;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1407:0] ks, input int r);
        return ks[1407 - 128 * r -: 128];
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
    end

    // Transaction-level model: busy flag, current round, expanded key list.
    bit            m_busy = 1'b0;
    bit            m_zero = 1'b1;
    int            m_round = 0;
    logic [1407:0] m_ks = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy  <= 1'b0;
            m_round <= 0;
            m_zero  <= 1'b1;
        end else if (!m_busy) begin
            if (key_valid) begin
                m_ks    <= expand(key_in);
                m_busy  <= 1'b1;
                m_round <= 0;
                m_zero  <= 1'b0;
            end
        end else if (rk_ready) begin
            if (m_round == 10) m_busy <= 1'b0;
            else m_round <= m_round + 1;
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string name, input logic a, input logic e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] a, input logic [3:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] a, input logic [127:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // ---------------- per-cycle compare + monitor ----------------
    bit           p_stall = 1'b0;
    bit           p_rst = 1'b0;
    logic [127:0] p_rk = '0;
    logic [3:0]   p_round = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("key_ready", key_ready, !m_busy);
            chk1("rk_valid", rk_valid, m_busy);
            chk1("rk_last", rk_last, m_busy && (m_round == 10));
            if (m_busy) begin
                chk128("rk", rk, rk_of(m_ks, m_round));
                chk4("rk_round", rk_round, 4'(m_round));
            end else if (m_zero) begin
                chk128("rk_after_reset", rk, 128'h0);
                chk4("rk_round_after_reset", rk_round, 4'd0);
            end
            if (p_stall && !p_rst) begin
                chk128("stall_rk_stable", rk, p_rk);
                chk4("stall_round_stable", rk_round, p_round);
            end
            if (rk_valid && rk_ready && !rst) begin
                beats.push_back(rk);
                if (rk_last) last_cyc.push_back(cyc);
            end
            if (key_ready && key_valid && !rst) acc_cyc.push_back(cyc);
        end
        p_stall <= rk_valid && !rk_ready;
        p_rst   <= rst;
        p_rk    <= rk;
        p_round <= rk_round;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: random 50% ready; 2: always ready, pulse other key during EMIT
    task automatic run_key(input logic [127:0] k, input int mode, input logic [127:0] other);
        int  n0 = beats.size();
        int  budget = 0;
        bit  acc = 1'b0;
        key_in    = k;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        while (!acc && budget < 50) begin
            acc = key_ready;
            tick();
            budget++;
        end
        chk1("key_accept_timeout", acc, 1'b1);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        budget = 0;
        while (beats.size() < n0 + 11 && budget < 300) begin
            rk_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
            if (mode == 2) begin
                key_valid = 1'($urandom % 2);
                key_in    = other;
            end
            tick();
            budget++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        chk_int("beat_count", beats.size() - n0, 11);
    endtask

    task automatic check_fips(input string tag, input int n0);
        if (beats.size() >= n0 + 11) begin
            chk128({tag, "_rk0"}, beats[n0], KEY_FIPS);
            chk128({tag, "_rk1"}, beats[n0 + 1], 128'ha0fafe1788542cb123a339392a6c7605);
            chk128({tag, "_rk10"}, beats[n0 + 10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end else begin
            chk_int({tag, "_beats_present"}, beats.size() - n0, 11);
        end
    endtask

    initial begin
        int n0;
        int a0;
        int l0;
        int budget;
        logic [127:0] ka;
        logic [127:0] kb;
        logic [1407:0] ks;

        #1;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Pin the model against FIPS-197 literal values.
        chk1("model_sbox_00", sbox_m[0] == 8'h63, 1'b1);
        chk1("model_sbox_53", sbox_m[8'h53] == 8'hed, 1'b1);
        ks = expand(KEY_FIPS);
        chk128("model_fips_rk1", rk_of(ks, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk128("model_fips_rk10", rk_of(ks, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ks = expand(128'h0);
        chk128("model_zero_rk1", rk_of(ks, 1), 128'h62636363626363636263636362636363);
        chk128("model_zero_rk10", rk_of(ks, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Test 1: FIPS key, no backpressure.
        n0 = beats.size();
        l0 = last_cyc.size();
        run_key(KEY_FIPS, 0, 128'h0);
        check_fips("t1", n0);
        chk_int("t1_last_seen", last_cyc.size() - l0, 1);

        // Test 2: all-zero key.
        n0 = beats.size();
        run_key(128'h0, 0, 128'h0);
        if (beats.size() >= n0 + 11) begin
            chk128("t2_rk1", beats[n0 + 1], 128'h62636363626363636263636362636363);
            chk128("t2_rk10", beats[n0 + 10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        end

        // Test 3: FIPS key with random backpressure.
        n0 = beats.size();
        run_key(KEY_FIPS, 1, 128'h0);
        check_fips("t3", n0);

        // Test 4: back-to-back keys with key_valid held high.
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        n0 = beats.size();
        a0 = acc_cyc.size();
        l0 = last_cyc.size();
        key_in = ka;
        key_valid = 1'b1;
        rk_ready = 1'b1;
        budget = 0;
        while (acc_cyc.size() < a0 + 1 && budget < 50) begin tick(); budget++; end
        key_in = kb;
        while (acc_cyc.size() < a0 + 2 && budget < 100) begin tick(); budget++; end
        key_valid = 1'b0;
        while (beats.size() < n0 + 22 && budget < 150) begin tick(); budget++; end
        rk_ready = 1'b0;
        chk_int("t4_beats", beats.size() - n0, 22);
        if (acc_cyc.size() >= a0 + 2 && last_cyc.size() >= l0 + 1)
            chk_int("t4_b_accept_cycle", acc_cyc[a0 + 1], last_cyc[l0] + 1);
        else
            chk_int("t4_handshakes_seen", acc_cyc.size() - a0, 2);
        if (beats.size() >= n0 + 22) begin
            chk128("t4_a_rk0", beats[n0], ka);
            chk128("t4_b_rk0", beats[n0 + 11], kb);
            chk128("t4_b_rk10", beats[n0 + 21], rk_of(expand(kb), 10));
        end

        // Test 5: reset while round 5 is presented.
        key_in = KEY_FIPS;
        key_valid = 1'b1;
        rk_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        budget = 0;
        while (!(rk_valid && rk_round == 4'd5) && budget < 50) begin tick(); budget++; end
        chk4("t5_reached_round5", rk_round, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rk_ready = 1'b0;
        chk1("t5_rk_valid", rk_valid, 1'b0);
        chk128("t5_rk", rk, 128'h0);
        chk4("t5_rk_round", rk_round, 4'd0);
        chk1("t5_key_ready", key_ready, 1'b1);
        tick();
        n0 = beats.size();
        run_key(KEY_FIPS, 0, 128'h0);
        check_fips("t5", n0);

        // Test 6: different key pulsed during EMIT is ignored.
        n0 = beats.size();
        run_key(KEY_FIPS, 2, 128'hdeadbeef0123456789abcdeffedcba98);
        check_fips("t6", n0);

        // Random keys with random backpressure against the model.
        for (int i = 0; i < 4; i++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            n0 = beats.size();
            run_key(ka, 1, 128'h0);
            if (beats.size() >= n0 + 11)
                chk128("rand_rk10", beats[n0 + 10], rk_of(expand(ka), 10));
        end

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
